audio_capture_writer: RTL and testbench
=======================================

# audio_capture_writer

Record-path counterpart to the flash playback engine. It pulls stereo samples from the audio core's read (ADC) FIFO using the read_s/read_ready handshake and mixes each pair to signed 16-bit mono. Each sample is written little-endian (LSB byte, then MSB byte) to a byte-wide, active-low-strobed external memory. The playback side can then stream the result back from the same byte layout.

## Interface
Parameters:
- ADDR_W, 22, byte-address width of the memory port
- MEM_BYTES, 4194304, capture length in bytes; must be even and ≤ 2^ADDR_W
- WR_HOLD, 3, cycles mem_we_n is held low per byte (≥1)

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin capture; sampled only in IDLE or DONE
- skip  in  1  0 = keep every sample, 1 = keep every other sample (first kept)
- busy  out  1  high from the cycle after start is accepted until DONE is entered
- done  out  1  level; high in DONE, cleared when the next start is accepted
- read_ready  in  1  audio core has a sample pair available
- readdata_left  in  16  signed left sample
- readdata_right  in  16  signed right sample
- read_s  out  1  read request to the audio core
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write data
- mem_ce_n  out  1  chip enable, active low
- mem_we_n  out  1  write strobe, active low

## Operation
- States: IDLE, WAIT_READY, WAIT_ACK, WR_SETUP, WR_PULSE, WR_END, DONE.
- Reset values: read_s=0, mem_we_n=1, mem_ce_n=1, mem_addr=0, mem_wdata=0, busy=0, done=0. Internal byte address=0, keep toggle=0, byte select=LSB.
- IDLE/DONE, start=1: clear done, set busy, zero the address and keep toggle, go to WAIT_READY. start is ignored in all other states.
- WAIT_READY: read_s=0.
  - If read_ready=1: latch left/right, set read_s<=1, go to WAIT_ACK.
- WAIT_ACK: hold read_s=1 until read_ready=0 is sampled, then read_s<=0.
  - If skip=1 and toggle=1: the sample is discarded. Flip toggle and return to WAIT_READY.
  - Otherwise: flip toggle (only when skip=1) and go to WR_SETUP with byte select=LSB.
- Mix: mono = (sext17(left) + sext17(right)) >>> 1 (arithmetic shift, floor), truncated to 16 bits. There is no overflow.
- WR_SETUP: mem_ce_n<=0, mem_addr<=address, mem_wdata<=mono[7:0] (LSB) or mono[15:8] (MSB), mem_we_n stays 1.
- WR_PULSE: mem_we_n=0 for exactly WR_HOLD cycles. Address and data stay stable throughout.
- WR_END: mem_we_n<=1, address<=address+1.
  - If byte select was LSB: set MSB, go to WR_SETUP.
  - Else if the new address equals MEM_BYTES: go to DONE.
  - Else: go to WAIT_READY.
- DONE: done=1, busy=0, mem_ce_n=1, read_s=0. read_ready is ignored. The address never wraps.
- mem_ce_n stays low from the first WR_SETUP until DONE. It is also low during handshakes mid-capture.

## Timing
- Handshake: read_s rises one cycle after read_ready=1 is sampled in WAIT_READY. It falls one cycle after read_ready=0 is sampled in WAIT_ACK. read_s never rises while a previous request is unacknowledged.
- Per byte: 1 setup cycle + WR_HOLD strobe cycles + 1 release cycle. The address is stable one cycle before the falling edge of mem_we_n and one cycle after its rising edge.
- Per kept sample with WR_HOLD=3: 10 write cycles plus the handshake. This is far below one 48 kHz frame period.
- Discarded samples still complete the full handshake, so the audio core FIFO is drained at the line rate.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous). In particular mem_we_n returns to 1 without waiting for a clock edge. A partial sample is not resumed.

## Test plan
- Reset: hold reset_n=0 with read_ready=1 and start=1 -> read_s=0, mem_we_n=1, mem_ce_n=1, mem_addr=0, busy=0, done=0.
- Single sample: start, then left=0x1234, right=0x1236 -> mono 0x1235. Address 0 is written 0x35, then address 1 is written 0x12. Each mem_we_n low pulse lasts exactly 3 cycles. read_s stays high until read_ready is driven low.
- Signed mix: left=0x8000, right=0xFFFF -> mono 0xBFFF, so bytes 0xFF then 0xBF. Separately, left=0x7FFF, right=0x7FFF -> 0x7FFF.
- Decimation: skip=1, feed samples A, B, C, D -> four handshakes complete, but only A and C are written, at addresses 0–3.
- End of capture: MEM_BYTES=8, feed 5 samples -> the first 4 are written, then done=1, busy=0, mem_ce_n=1. The 5th read_ready gets no read_s. A new start restarts at address 0 and clears done.
- Mid-write reset: drop reset_n while mem_we_n=0 -> mem_we_n=1 before the next clock edge. After release, start -> writing begins at address 0.

Source files
------------

// File: rtl/audio_capture_writer.sv
// Record path: pulls stereo pairs from the audio core ADC FIFO, mixes them to signed 16-bit mono
// and writes each sample little-endian to a byte-wide, active-low-strobed external memory.
module audio_capture_writer #(
    parameter int ADDR_W    = 22,
    parameter int MEM_BYTES = 4194304,
    parameter int WR_HOLD   = 3
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              start,
    input  logic              skip,
    output logic              busy,
    output logic              done,
    input  logic              read_ready,
    input  logic [15:0]       readdata_left,
    input  logic [15:0]       readdata_right,
    output logic              read_s,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_ce_n,
    output logic              mem_we_n
);

    localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WR_HOLD - 1);
    // One extra address bit so a capture covering the whole 2^ADDR_W space still sees its end.
    localparam logic [ADDR_W:0] END_ADDR = (ADDR_W + 1)'(MEM_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        WAIT_ACK,
        WR_SETUP,
        WR_PULSE,
        WR_END,
        DONE
    } state_t;

    state_t state, next_state;

    logic [ADDR_W:0]     addr;
    logic [ADDR_W:0]     addr_next;
    logic                keep_toggle;
    logic                byte_msb;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [15:0]         left_q;
    logic [15:0]         right_q;
    logic signed [16:0]  mix_sum;
    logic [15:0]         mono;

    assign addr_next = addr + 1'b1;
    assign mix_sum   = {left_q[15], left_q} + {right_q[15], right_q};
    assign mono      = 16'(mix_sum >>> 1);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) next_state = WAIT_READY;
            end
            WAIT_READY: begin
                if (read_ready) next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!read_ready) next_state = (skip && keep_toggle) ? WAIT_READY : WR_SETUP;
            end
            WR_SETUP: next_state = WR_PULSE;
            WR_PULSE: begin
                if (hold_cnt == HOLD_LAST) next_state = WR_END;
            end
            WR_END: begin
                if (!byte_msb)                 next_state = WR_SETUP;
                else if (addr_next == END_ADDR) next_state = DONE;
                else                           next_state = WAIT_READY;
            end
            default: next_state = IDLE;
        endcase
    end

    // Memory outputs are loaded on the edge entering WR_SETUP so address and data
    // are already stable for the whole setup cycle before the strobe falls.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            read_s      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_ce_n    <= 1'b1;
            mem_we_n    <= 1'b1;
            addr        <= '0;
            keep_toggle <= 1'b0;
            byte_msb    <= 1'b0;
            hold_cnt    <= '0;
            left_q      <= '0;
            right_q     <= '0;
        end else begin
            mem_we_n <= (next_state != WR_PULSE);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        addr        <= '0;
                        keep_toggle <= 1'b0;
                    end
                end
                WAIT_READY: begin
                    if (read_ready) begin
                        left_q  <= readdata_left;
                        right_q <= readdata_right;
                        read_s  <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (!read_ready) begin
                        read_s <= 1'b0;
                        if (skip) keep_toggle <= ~keep_toggle;
                        if (!(skip && keep_toggle)) begin
                            byte_msb  <= 1'b0;
                            mem_ce_n  <= 1'b0;
                            mem_addr  <= addr[ADDR_W-1:0];
                            mem_wdata <= mono[7:0];
                        end
                    end
                end
                WR_SETUP: hold_cnt <= '0;
                WR_PULSE: hold_cnt <= hold_cnt + 1'b1;
                WR_END: begin
                    addr <= addr_next;
                    if (!byte_msb) begin
                        byte_msb  <= 1'b1;
                        mem_addr  <= addr_next[ADDR_W-1:0];
                        mem_wdata <= mono[15:8];
                    end else if (addr_next == END_ADDR) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        mem_ce_n <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_capture_writer.sv
// Scoreboard bench for audio_capture_writer: every accepted sample pushes its expected
// byte writes; a memory-bus monitor pops and compares them as each strobe completes.
module tb_audio_capture_writer;

    localparam int ADDR_W    = 22;
    localparam int MEM_BYTES = 8;
    localparam int WR_HOLD   = 3;

    logic              CLOCK_50 = 1'b0;
    logic              reset_n;
    logic              start;
    logic              skip;
    logic              busy;
    logic              done;
    logic              read_ready;
    logic [15:0]       readdata_left;
    logic [15:0]       readdata_right;
    logic              read_s;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ce_n;
    logic              mem_we_n;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0]       sb[$];
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_toggle;
    logic              mon_en = 1'b1;

    audio_capture_writer #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES),
        .WR_HOLD   (WR_HOLD)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset_n        (reset_n),
        .start          (start),
        .skip           (skip),
        .busy           (busy),
        .done           (done),
        .read_ready     (read_ready),
        .readdata_left  (readdata_left),
        .readdata_right (readdata_right),
        .read_s         (read_s),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ce_n       (mem_ce_n),
        .mem_we_n       (mem_we_n)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] mono_of(input logic [15:0] l, input logic [15:0] r);
        int s;
        s = int'($signed(l)) + int'($signed(r));
        return 16'(s >>> 1);
    endfunction

    task automatic model_reset();
        exp_addr   = '0;
        exp_toggle = 1'b0;
    endtask

    // Model of one accepted handshake: decimation decision and the two expected byte writes.
    task automatic push_sample(input logic [15:0] l, input logic [15:0] r);
        logic        keep;
        logic [15:0] m;
        keep = !skip || !exp_toggle;
        if (skip) exp_toggle = ~exp_toggle;
        if (keep) begin
            m = mono_of(l, r);
            sb.push_back(32'({exp_addr, m[7:0]}));
            sb.push_back(32'({exp_addr + 1'b1, m[15:8]}));
            exp_addr = exp_addr + 2'd2;
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] l, input logic [15:0] r);
        bit seen = 0;
        readdata_left  = l;
        readdata_right = r;
        read_ready     = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge CLOCK_50);
            seen = read_s;
        end
        check_output("read_s_rise", 32'(seen), 1);
        if (seen) begin
            push_sample(l, r);
            repeat (2) @(negedge CLOCK_50);
            check_output("read_s_hold", 32'(read_s), 1);
        end
        read_ready = 1'b0;
        @(negedge CLOCK_50);
        check_output("read_s_fall", 32'(read_s), 0);
    endtask

    task automatic start_capture();
        @(negedge CLOCK_50);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        check_output("start_busy", 32'(busy), 1);
        check_output("start_done_clr", 32'(done), 0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge CLOCK_50);
        check_output("sb_drained", sb.size(), 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && !done; i++) @(negedge CLOCK_50);
        check_output("done_set", 32'(done), 1);
        check_output("done_busy", 32'(busy), 0);
        check_output("done_ce_n", 32'(mem_ce_n), 1);
        check_output("done_sb_empty", sb.size(), 0);
    endtask

    // Bus monitor: checks setup/hold stability and strobe width, then scores each written byte.
    logic              prev_we = 1'b1;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [ADDR_W-1:0] cap_addr = '0;
    logic [7:0]        cap_data = '0;
    int                low_cnt = 0;

    always @(negedge CLOCK_50) begin
        if (!mon_en) begin
            prev_we <= 1'b1;
        end else begin
            if (prev_we && !mem_we_n) begin
                cap_addr <= mem_addr;
                cap_data <= mem_wdata;
                low_cnt  <= 1;
                check_output("setup_addr", 32'(mem_addr), 32'(prev_addr));
                check_output("ce_low", 32'(mem_ce_n), 0);
            end else if (!prev_we && !mem_we_n) begin
                low_cnt <= low_cnt + 1;
                check_output("pulse_stable", 32'({mem_addr, mem_wdata}), 32'({cap_addr, cap_data}));
            end else if (!prev_we && mem_we_n) begin
                check_output("we_width", low_cnt, WR_HOLD);
                check_output("release_addr", 32'(mem_addr), 32'(cap_addr));
                if (sb.size() == 0) check_output("sb_underflow", sb.size(), 1);
                else check_output("byte_write", 32'({cap_addr, cap_data}), sb.pop_front());
            end
            prev_we <= mem_we_n;
        end
        prev_addr <= mem_addr;
    end

    initial begin
        bit seen;
        reset_n        = 1'b0;
        start          = 1'b1;
        read_ready     = 1'b1;
        skip           = 1'b0;
        readdata_left  = '0;
        readdata_right = '0;
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        check_output("rst_read_s", 32'(read_s), 0);
        check_output("rst_we_n", 32'(mem_we_n), 1);
        check_output("rst_ce_n", 32'(mem_ce_n), 1);
        check_output("rst_addr", 32'(mem_addr), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_done", 32'(done), 0);
        reset_n    = 1'b1;
        start      = 1'b0;
        read_ready = 1'b0;
        @(negedge CLOCK_50);

        $display("[TB] full capture, no decimation");
        start_capture();
        apply_stimulus(16'h1234, 16'h1236);
        apply_stimulus(16'h8000, 16'hFFFF);
        apply_stimulus(16'h7FFF, 16'h7FFF);
        apply_stimulus(16'($urandom), 16'($urandom));
        wait_done();
        read_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            if (read_s) seen = 1;
        end
        check_output("done_no_read_s", 32'(seen), 0);
        read_ready = 1'b0;
        model_reset();
        start_capture();
        apply_stimulus(16'h0100, 16'h0300);
        wait_drain();

        $display("[TB] decimated capture");
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        skip    = 1'b1;
        model_reset();
        start_capture();
        apply_stimulus(16'h0010, 16'h0020);
        apply_stimulus(16'h1111, 16'h2222);
        apply_stimulus(16'hFFFE, 16'hFFFC);
        apply_stimulus(16'h3333, 16'h4444);
        apply_stimulus(16'h4000, 16'hC000);
        apply_stimulus(16'h5555, 16'h6666);
        apply_stimulus(16'h8001, 16'h8001);
        wait_done();

        $display("[TB] reset during write strobe");
        skip = 1'b0;
        model_reset();
        start_capture();
        apply_stimulus(16'hAAAA, 16'h5555);
        for (int i = 0; i < 50 && mem_we_n; i++) @(negedge CLOCK_50);
        check_output("we_low_seen", 32'(mem_we_n), 0);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_output("async_we_n", 32'(mem_we_n), 1);
        check_output("async_ce_n", 32'(mem_ce_n), 1);
        check_output("async_addr", 32'(mem_addr), 0);
        check_output("async_busy", 32'(busy), 0);
        sb.delete();
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        mon_en = 1'b1;
        model_reset();
        start_capture();
        apply_stimulus(16'h1234, 16'h1236);
        wait_drain();

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
